// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM encoding, requester IDs, default widths.
// The optional round-robin CPU/SPI policy is selected by the SRAM_ARB_RR_EN macro.
package sram_port_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SHARED    = 2'd2,
        SPI_BURST = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_LD   = 2'd1,
        REQ_CPU  = 2'd2,
        REQ_SPI  = 2'd3
    } req_id_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundles the requester, SRAM and debug signals of the arbiter; slave = arbiter side,
// master = requesters plus SRAM. No macro dependence (SRAM_ARB_RR_EN only affects the picker).
interface sram_port_arbiter_if #(
    parameter int DW = sram_port_arbiter_pkg::DEF_DATA_WIDTH,
    parameter int AW = sram_port_arbiter_pkg::DEF_ADDR_WIDTH
);
    import sram_port_arbiter_pkg::*;

    // Handshake: *_REQ is a level held stable until *_GNT is seen high in the same
    // cycle; a granted read returns data on RD_Q with a one-cycle *_QV pulse next cycle.
    logic          LD_REQ;
    logic          LD_WE;
    logic [AW-1:0] LD_A;
    logic [DW-1:0] LD_D;
    logic          CPU_REQ;
    logic          CPU_WE;
    logic [AW-1:0] CPU_A;
    logic [DW-1:0] CPU_D;
    logic          SPI_REQ;
    logic          SPI_LOCK;
    logic          SPI_WE;
    logic [AW-1:0] SPI_A;
    logic [DW-1:0] SPI_D;

    logic          LD_GNT;
    logic          CPU_GNT;
    logic          SPI_GNT;
    logic          LD_QV;
    logic          CPU_QV;
    logic          SPI_QV;
    logic [DW-1:0] RD_Q;
    logic          LD_BUSY;

    logic          CEN;
    logic          WEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;

    state_t        dbg_state;
    logic          dbg_rr_ptr;

    modport slave (
        input  LD_REQ, LD_WE, LD_A, LD_D,
        input  CPU_REQ, CPU_WE, CPU_A, CPU_D,
        input  SPI_REQ, SPI_LOCK, SPI_WE, SPI_A, SPI_D,
        input  Q,
        output LD_GNT, CPU_GNT, SPI_GNT, LD_QV, CPU_QV, SPI_QV, RD_Q, LD_BUSY,
        output CEN, WEN, A, D,
        output dbg_state, dbg_rr_ptr
    );

    modport master (
        output LD_REQ, LD_WE, LD_A, LD_D,
        output CPU_REQ, CPU_WE, CPU_A, CPU_D,
        output SPI_REQ, SPI_LOCK, SPI_WE, SPI_A, SPI_D,
        output Q,
        input  LD_GNT, CPU_GNT, SPI_GNT, LD_QV, CPU_QV, SPI_QV, RD_Q, LD_BUSY,
        input  CEN, WEN, A, D,
        input  dbg_state, dbg_rr_ptr
    );

endinterface

// File: rtl/sram_arb_rr2.sv
// Two-way CPU(a)/SPI(b) picker. With SRAM_ARB_RR_EN a pointer alternates contended wins;
// otherwise a fixed a-over-b priority and no pointer register.
module sram_arb_rr2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic ptr_o
);

`ifdef SRAM_ARB_RR_EN
    logic ptr_q;
    logic ptr_d;

    // ptr_q = 0 means a wins the next contended cycle
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        ptr_d = ptr_q;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = !ptr_q;
                gnt_b = ptr_q;
                ptr_d = !ptr_q;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
`else
    logic unused_clk_rst;

    assign gnt_a          = en & req_a;
    assign gnt_b          = en & req_b & ~req_a;
    assign ptr_o          = 1'b0;
    assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: loader preempts everything, CPU/SPI share the port (policy set by
// SRAM_ARB_RR_EN), SPI may lock the port for bursts. Reads return data one cycle after grant.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int MEMORY_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEMORY_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic                CLK,
    input logic                RST,
    sram_port_arbiter_if.slave bus
);

    state_t                       state_q;
    logic                         ld_qv_q;
    logic                         cpu_qv_q;
    logic                         spi_qv_q;
    logic                         ld_busy_q;
    logic [MEMORY_ADDR_WIDTH-1:0] a_q;
    logic [MEMORY_DATA_WIDTH-1:0] d_q;

    logic                         pick_en;
    logic                         cpu_pick;
    logic                         spi_pick;
    logic                         rr_ptr;
    logic                         ld_gnt;
    logic                         cpu_gnt;
    logic                         spi_gnt;
    logic                         any_gnt;
    logic                         any_qv;
    logic                         win_we;
    logic [MEMORY_ADDR_WIDTH-1:0] win_a;
    logic [MEMORY_DATA_WIDTH-1:0] win_d;

    // The picker only decides when neither the loader nor an SPI burst owns the port.
    assign pick_en = !RST && !bus.LD_REQ && (state_q != SPI_BURST);

    sram_arb_rr2 u_pick (
        .clk   (CLK),
        .rst   (RST),
        .en    (pick_en),
        .req_a (bus.CPU_REQ),
        .req_b (bus.SPI_REQ),
        .gnt_a (cpu_pick),
        .gnt_b (spi_pick),
        .ptr_o (rr_ptr)
    );

    assign ld_gnt  = !RST && bus.LD_REQ;
    assign cpu_gnt = cpu_pick;
    assign spi_gnt = spi_pick ||
                     (!RST && !bus.LD_REQ && (state_q == SPI_BURST) && bus.SPI_REQ);
    assign any_gnt = ld_gnt || cpu_gnt || spi_gnt;

    always_comb begin
        win_we = 1'b0;
        win_a  = a_q;
        win_d  = d_q;
        if (ld_gnt) begin
            win_we = bus.LD_WE;
            win_a  = bus.LD_A;
            win_d  = bus.LD_D;
        end else if (cpu_gnt) begin
            win_we = bus.CPU_WE;
            win_a  = bus.CPU_A;
            win_d  = bus.CPU_D;
        end else if (spi_gnt) begin
            win_we = bus.SPI_WE;
            win_a  = bus.SPI_A;
            win_d  = bus.SPI_D;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ld_qv_q   <= 1'b0;
            cpu_qv_q  <= 1'b0;
            spi_qv_q  <= 1'b0;
            ld_busy_q <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
        end else begin
            ld_qv_q   <= ld_gnt && !bus.LD_WE;
            cpu_qv_q  <= cpu_gnt && !bus.CPU_WE;
            spi_qv_q  <= spi_gnt && !bus.SPI_WE;
            ld_busy_q <= bus.LD_REQ;
            if (any_gnt) begin
                a_q <= win_a;
                d_q <= win_d;
            end
            if (bus.LD_REQ) begin
                state_q <= LOAD;
            end else begin
                case (state_q)
                    LOAD: state_q <= IDLE;
                    IDLE: begin
                        if (bus.CPU_REQ || bus.SPI_REQ) state_q <= SHARED;
                    end
                    SHARED: begin
                        if (spi_gnt && bus.SPI_LOCK) begin
                            state_q <= SPI_BURST;
                        end else if (!(bus.CPU_REQ || bus.SPI_REQ)) begin
                            state_q <= IDLE;
                        end
                    end
                    SPI_BURST: begin
                        if (!bus.SPI_LOCK) state_q <= SHARED;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Strobes are masked by RST so a read in flight at reset never reports.
    assign bus.LD_QV   = ld_qv_q && !RST;
    assign bus.CPU_QV  = cpu_qv_q && !RST;
    assign bus.SPI_QV  = spi_qv_q && !RST;
    assign any_qv      = bus.LD_QV || bus.CPU_QV || bus.SPI_QV;
    assign bus.RD_Q    = any_qv ? bus.Q : '0;

    assign bus.LD_GNT  = ld_gnt;
    assign bus.CPU_GNT = cpu_gnt;
    assign bus.SPI_GNT = spi_gnt;
    assign bus.CEN     = !any_gnt;
    assign bus.WEN     = !win_we;
    assign bus.A       = win_a;
    assign bus.D       = win_d;
    assign bus.LD_BUSY = ld_busy_q;

    assign bus.dbg_state  = state_q;
    assign bus.dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with an SRAM model and a rule-level reference model;
// expectations follow SRAM_ARB_RR_EN when it is defined.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int AW = DEF_ADDR_WIDTH;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sram_port_arbiter_if #(.DW(DW), .AW(AW)) bus();

    sram_port_arbiter #(
        .MEMORY_DATA_WIDTH (DW),
        .MEMORY_ADDR_WIDTH (AW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        logic [DW-1:0] v;
        v = i[DW-1:0];
        return v ^ 8'h3C;
    endfunction

    // ---------------- SRAM model ----------------
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (bus.CEN === 1'b0) begin
            if (bus.WEN === 1'b0) sram[bus.A] <= bus.D;
            else                  bus.Q <= sram[bus.A];
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0]   m_mem [0:(1<<AW)-1];
    bit              m_load, m_shared, m_burst, m_spi_first;
    logic [AW-1:0]   m_a = '0;
    logic [DW-1:0]   m_d = '0;
    logic [DW+1:0]   exp_q[$];

    always @(negedge CLK) begin
        int            who;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW+1:0] e;
        logic [2:0]    exp_qv;
        state_t        exp_st;
        bit            any_cs;
        bit            contended;
        if (model_on) begin
            // who: 0 none, 1 loader, 2 cpu, 3 spi
            who = 0;
            if (RST)                              who = 0;
            else if (bus.LD_REQ)                  who = 1;
            else if (m_burst)                     who = bus.SPI_REQ ? 3 : 0;
            else if (bus.CPU_REQ && bus.SPI_REQ)  who = (RR && m_spi_first) ? 3 : 2;
            else if (bus.CPU_REQ)                 who = 2;
            else if (bus.SPI_REQ)                 who = 3;
            we = 1'b0; a = m_a; d = m_d;
            case (who)
                1: begin we = bus.LD_WE;  a = bus.LD_A;  d = bus.LD_D;  end
                2: begin we = bus.CPU_WE; a = bus.CPU_A; d = bus.CPU_D; end
                3: begin we = bus.SPI_WE; a = bus.SPI_A; d = bus.SPI_D; end
                default: ;
            endcase
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            exp_qv = 3'b000;
            if (!RST && e[DW+1:DW] != 2'd0) exp_qv[3 - int'(e[DW+1:DW])] = 1'b1;
            exp_st = m_load ? LOAD : (m_burst ? SPI_BURST : (m_shared ? SHARED : IDLE));

            chk("m_gnt", 32'({bus.LD_GNT, bus.CPU_GNT, bus.SPI_GNT}),
                32'({who == 1, who == 2, who == 3}));
            chk("m_cen", 32'(bus.CEN), 32'(who == 0));
            chk("m_wen", 32'(bus.WEN), 32'(!(who != 0 && we)));
            chk("m_a", 32'(bus.A), 32'(a));
            chk("m_d", 32'(bus.D), 32'(d));
            chk("m_qv", 32'({bus.LD_QV, bus.CPU_QV, bus.SPI_QV}), 32'(exp_qv));
            if (exp_qv != 3'b000) chk("m_rd_q", 32'(bus.RD_Q), 32'(e[DW-1:0]));
            chk("m_ld_busy", 32'(bus.LD_BUSY), 32'(m_load));
            chk("m_state", 32'(bus.dbg_state), 32'(exp_st));
            chk("m_rr_ptr", 32'(bus.dbg_rr_ptr), 32'(m_spi_first));

            if (RST) begin
                m_load = 0; m_shared = 0; m_burst = 0; m_spi_first = 0;
                m_a = '0; m_d = '0;
                exp_q.delete();
            end else begin
                if (who != 0) begin
                    m_a = a; m_d = d;
                    if (we) m_mem[a] = d;
                end
                exp_q.push_back((who != 0 && !we) ? {who[1:0], m_mem[a]} : '0);
                any_cs    = bus.CPU_REQ || bus.SPI_REQ;
                contended = !bus.LD_REQ && !m_burst && bus.CPU_REQ && bus.SPI_REQ;
                if (RR && contended) m_spi_first = !m_spi_first;
                if (bus.LD_REQ) begin
                    m_load = 1; m_shared = 0; m_burst = 0;
                end else if (m_load) begin
                    m_load = 0;
                end else if (m_burst) begin
                    if (!bus.SPI_LOCK) begin m_burst = 0; m_shared = 1; end
                end else if (m_shared) begin
                    if (who == 3 && bus.SPI_LOCK) begin m_shared = 0; m_burst = 1; end
                    else if (!any_cs) m_shared = 0;
                end else if (any_cs) begin
                    m_shared = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next();
        @(posedge CLK); #1;
    endtask

    task automatic to_mid();
        @(negedge CLK); #1;
    endtask

    task automatic set_ld(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.LD_REQ = req; bus.LD_WE = we; bus.LD_A = a; bus.LD_D = d;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.CPU_REQ = req; bus.CPU_WE = we; bus.CPU_A = a; bus.CPU_D = d;
    endtask

    task automatic set_spi(input logic req, input logic lock, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.SPI_REQ = req; bus.SPI_LOCK = lock; bus.SPI_WE = we; bus.SPI_A = a; bus.SPI_D = d;
    endtask

    task automatic idle_all();
        set_ld(1'b0, 1'b0, '0, '0);
        set_cpu(1'b0, 1'b0, '0, '0);
        set_spi(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        idle_all();
        bus.Q = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]  = init_val(i);
            m_mem[i] = init_val(i);
        end
        RST = 1'b1;
        next();
        model_on = 1'b1;
        next();
        to_mid();
        chk("rst_cen", 32'(bus.CEN), 32'h1);
        chk("rst_a", 32'(bus.A), 32'h0);
        chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        next();

        // Loader write then read back, granted in the first cycle out of reset
        RST = 1'b0;
        set_ld(1'b1, 1'b1, 9'h010, 8'h5A);
        to_mid();
        chk("s1_ld_gnt_w", 32'(bus.LD_GNT), 32'h1);
        chk("s1_wen_w", 32'(bus.WEN), 32'h0);
        chk("s1_a_w", 32'(bus.A), 32'h010);
        next();
        set_ld(1'b1, 1'b0, 9'h010, 8'h00);
        to_mid();
        chk("s1_ld_gnt_r", 32'(bus.LD_GNT), 32'h1);
        chk("s1_wen_r", 32'(bus.WEN), 32'h1);
        next();
        set_ld(1'b0, 1'b0, '0, '0);
        to_mid();
        chk("s1_ld_qv", 32'(bus.LD_QV), 32'h1);
        chk("s1_rd_q", 32'(bus.RD_Q), 32'h5A);
        chk("s1_ld_busy", 32'(bus.LD_BUSY), 32'h1);
        next();

        // CPU and SPI reading continuously
        set_cpu(1'b1, 1'b0, 9'h020, 8'h00);
        set_spi(1'b1, 1'b0, 1'b0, 9'h030, 8'h00);
        for (int i = 0; i < 6; i++) begin
            to_mid();
            chk("s2_cpu_gnt", 32'(bus.CPU_GNT), 32'(RR ? (i % 2 == 0) : 1'b1));
            chk("s2_spi_gnt", 32'(bus.SPI_GNT), 32'(RR ? (i % 2 == 1) : 1'b0));
            if (i > 0) begin
                chk("s2_cpu_qv", 32'(bus.CPU_QV), 32'(RR ? (i % 2 == 1) : 1'b1));
                chk("s2_rd_q", 32'(bus.RD_Q), (RR && (i % 2 == 0)) ? 32'h0C : 32'h1C);
            end
            next();
        end
        idle_all();
        next();

        // SPI burst locks out the CPU
        set_spi(1'b1, 1'b1, 1'b0, 9'h040, 8'h00);
        to_mid();
        chk("s3_spi_gnt0", 32'(bus.SPI_GNT), 32'h1);
        next();
        to_mid();
        chk("s3_spi_gnt1", 32'(bus.SPI_GNT), 32'h1);
        next();
        set_cpu(1'b1, 1'b0, 9'h050, 8'h00);
        for (int i = 0; i < 4; i++) begin
            to_mid();
            chk("s3_cpu_locked", 32'(bus.CPU_GNT), 32'h0);
            chk("s3_spi_burst", 32'(bus.SPI_GNT), 32'h1);
            chk("s3_state", 32'(bus.dbg_state), 32'(SPI_BURST));
            next();
        end
        set_spi(1'b0, 1'b0, 1'b0, '0, '0);
        to_mid();
        chk("s3_unlock_cpu", 32'(bus.CPU_GNT), 32'h0);
        chk("s3_unlock_cen", 32'(bus.CEN), 32'h1);
        next();
        to_mid();
        chk("s3_cpu_after", 32'(bus.CPU_GNT), 32'h1);
        next();
        idle_all();
        next();

        // SPI_LOCK without SPI_REQ must not enter a burst
        set_cpu(1'b1, 1'b0, 9'h060, 8'h00);
        set_spi(1'b0, 1'b1, 1'b0, '0, '0);
        next();
        next();
        to_mid();
        chk("s3b_state", 32'(bus.dbg_state), 32'(SHARED));
        next();
        idle_all();
        next();

        // CPU read at the top address, then the loader preempts
        set_cpu(1'b1, 1'b0, 9'h1FF, 8'h00);
        to_mid();
        chk("s4_cpu_gnt", 32'(bus.CPU_GNT), 32'h1);
        chk("s4_a", 32'(bus.A), 32'h1FF);
        next();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_ld(1'b1, 1'b0, 9'h011, 8'h00);
        to_mid();
        chk("s4_cpu_qv", 32'(bus.CPU_QV), 32'h1);
        chk("s4_rd_q", 32'(bus.RD_Q), 32'hC3);
        chk("s4_ld_gnt", 32'(bus.LD_GNT), 32'h1);
        chk("s4_ld_busy0", 32'(bus.LD_BUSY), 32'h0);
        next();
        set_ld(1'b0, 1'b0, '0, '0);
        to_mid();
        chk("s4_ld_busy1", 32'(bus.LD_BUSY), 32'h1);
        chk("s4_ld_rd_q", 32'(bus.RD_Q), 32'h2D);
        next();

        // Reset right after a granted SPI read
        set_spi(1'b1, 1'b0, 1'b0, 9'h030, 8'h00);
        to_mid();
        chk("s5_spi_gnt", 32'(bus.SPI_GNT), 32'h1);
        next();
        set_spi(1'b0, 1'b0, 1'b0, '0, '0);
        set_ld(1'b1, 1'b1, 9'h070, 8'hEE);
        RST = 1'b1;
        to_mid();
        chk("s5_spi_qv", 32'(bus.SPI_QV), 32'h0);
        chk("s5_ld_gnt", 32'(bus.LD_GNT), 32'h0);
        chk("s5_cen", 32'(bus.CEN), 32'h1);
        chk("s5_wen", 32'(bus.WEN), 32'h1);
        next();
        set_ld(1'b0, 1'b0, '0, '0);
        RST = 1'b0;
        to_mid();
        chk("s5_state", 32'(bus.dbg_state), 32'(IDLE));
        chk("s5_a", 32'(bus.A), 32'h0);
        next();

        // One contended cycle, then ten idle cycles
        set_cpu(1'b1, 1'b0, 9'h020, 8'h00);
        set_spi(1'b1, 1'b0, 1'b0, 9'h030, 8'h00);
        to_mid();
        chk("s6_cpu_gnt", 32'(bus.CPU_GNT), 32'h1);
        next();
        idle_all();
        for (int i = 0; i < 10; i++) begin
            to_mid();
            chk("s6_cen", 32'(bus.CEN), 32'h1);
            chk("s6_gnt", 32'({bus.LD_GNT, bus.CPU_GNT, bus.SPI_GNT}), 32'h0);
            chk("s6_rr_ptr", 32'(bus.dbg_rr_ptr), 32'(RR));
            next();
        end
        chk("s6_sram_070", 32'(sram[9'h070]), 32'(init_val(9'h070)));

        next();
        next();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
